sync_fifo_fwft: RTL and testbench



---
 rtl/ram_simple.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 62 ++++++
 tb/tb_sync_fifo_fwft.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ram_simple.sv
// ram_simple: two-port block RAM, one write port and one registered read port.
// The read-data register only updates when i_rd_en is high, otherwise it holds.
module ram_simple #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= mem[i_rd_addr];
    end
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO controller around ram_simple.
// The RAM read register is the visible head word; head_vld says whether it is live.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          head_vld;
    logic          wr_acc, rd_acc, rd_iss;

    assign o_empty = !head_vld;
    assign o_count = ram_cnt + CW'(head_vld);
    assign o_full  = o_count == CW'(DEPTH);
    assign wr_acc  = i_wr_en && !o_full;
    assign rd_acc  = i_rd_en && head_vld;
    // ram_cnt is registered, so a read never targets a word written at this same edge
    assign rd_iss  = (ram_cnt != '0) && (!head_vld || rd_acc);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            head_vld    <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(wr_acc);
            rd_ptr      <= rd_ptr + AW'(rd_iss);
            ram_cnt     <= ram_cnt + CW'(wr_acc) - CW'(rd_iss);
            head_vld    <= rd_iss || (head_vld && !rd_acc);
            o_overflow  <= i_wr_en && o_full;
            o_underflow <= i_rd_en && !head_vld;
        end
    end

    ram_simple #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (rd_iss),
        .i_rd_addr (rd_ptr),
        .o_rd_data (o_data)
    );
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: vector table, corner sequences and random traffic checked
// against a queue model where a pushed word becomes visible two cycles later.
module tb_sync_fifo_fwft;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1, we = 1'b0, re = 1'b0;
    logic [W-1:0]  wd = '0, od;
    logic          emp, full, ovf, unf;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wr_en     (we),
        .i_wr_data   (wd),
        .i_rd_en     (re),
        .o_data      (od),
        .o_empty     (emp),
        .o_full      (full),
        .o_count     (cnt),
        .o_overflow  (ovf),
        .o_underflow (unf)
    );

    typedef struct {
        logic [W-1:0] d;
        int           rdy;
    } ent_t;

    typedef struct {
        bit           we, re, rs;
        logic [W-1:0] d;
        bit           e_emp;
        int           e_cnt;
        bit           e_unf;
        logic [W-1:0] e_dat;
    } vec_t;

    ent_t q[$];
    vec_t tv[12];
    int   cyc = 0, total = 0, bad = 0;
    bit   m_ovf = 0, m_unf = 0;

    task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic bit vis();
        return q.size() > 0 && q[0].rdy <= cyc;
    endfunction

    task automatic step(input bit w, input bit r, input bit rs, input logic [W-1:0] d);
        bit v, f;
        we = w; re = r; rst = rs; wd = d;
        v = vis();
        f = q.size() == D;
        if (rs) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_ovf = w && f;
            m_unf = r && !v;
            if (r && v) void'(q.pop_front());
            if (w && !f) q.push_back('{d, cyc + 2});
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("empty", W'(emp), W'(!vis()));
        chk("count", W'(cnt), W'(q.size()));
        chk("full", W'(full), W'(q.size() == D));
        chk("overflow", W'(ovf), W'(m_ovf));
        chk("underflow", W'(unf), W'(m_unf));
        if (vis()) chk("data", od, q[0].d);
    endtask

    initial begin
        int k, pw;
        tv[0]  = '{0, 0, 1, 0,             1, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0,             1, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0,             1, 0, 0, 0};
        tv[3]  = '{0, 0, 0, 0,             1, 0, 0, 0};
        tv[4]  = '{1, 0, 0, 32'hA5A5_0001, 1, 1, 0, 0};
        tv[5]  = '{0, 0, 0, 0,             0, 1, 0, 32'hA5A5_0001};
        tv[6]  = '{0, 0, 0, 0,             0, 1, 0, 32'hA5A5_0001};
        tv[7]  = '{0, 0, 0, 0,             0, 1, 0, 32'hA5A5_0001};
        tv[8]  = '{0, 1, 0, 0,             1, 0, 0, 0};
        tv[9]  = '{1, 1, 0, 32'h1234,      1, 1, 1, 0};
        tv[10] = '{0, 0, 0, 0,             0, 1, 0, 32'h1234};
        tv[11] = '{0, 1, 0, 0,             1, 0, 0, 0};
        foreach (tv[i]) begin
            step(tv[i].we, tv[i].re, tv[i].rs, tv[i].d);
            chk("vec_empty", W'(emp), W'(tv[i].e_emp));
            chk("vec_count", W'(cnt), W'(tv[i].e_cnt));
            chk("vec_underflow", W'(unf), W'(tv[i].e_unf));
            if (!tv[i].e_emp) chk("vec_data", od, tv[i].e_dat);
        end
        repeat (10) step(0, 0, 0, 0);

        step(0, 0, 1, 0);
        for (int i = 0; i < D; i++) step(1, 0, 0, W'(i));
        chk("fill_full", W'(full), 1);
        step(1, 0, 0, 32'hDEAD);
        chk("fill_ovf", W'(ovf), 1);
        chk("fill_cnt", W'(cnt), W'(D));
        step(0, 0, 0, 0);
        chk("fill_ovf_pulse", W'(ovf), 0);
        for (int i = 0; i < D; i++) begin
            chk("fill_order", od, W'(i));
            step(0, 1, 0, 0);
        end
        chk("drained", W'(emp), 1);

        step(0, 0, 1, 0);
        k = 0;
        for (int i = 0; i < 102; i++) begin
            if (!emp) begin
                chk("stream_data", od, W'(1000 + k));
                k++;
            end
            if (i >= 3) chk("stream_cnt", W'(cnt), 2);
            step(1, 1, 0, W'(1000 + i));
        end
        chk("stream_words", W'(k), 100);

        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, W'(i + 7));
        step(1, 1, 1, 32'h5555);
        chk("rst_empty", W'(emp), 1);
        chk("rst_count", W'(cnt), 0);
        step(1, 0, 0, 32'hBEEF);
        step(0, 0, 0, 0);
        chk("rst_next", od, 32'hBEEF);
        step(0, 1, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            pw = ((i / 400) % 2) ? 80 : 35;
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 399) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
